nbit_comparator_stream: RTL and testbench

Registered, handshaked N-bit magnitude comparator for streaming sample pairs. It adds the following on top of a plain combinational compare:
- per-transfer signed or unsigned mode
- valid/ready flow control with backpressure
- a "result changed" flag
- saturating per-outcome event counters

It sits between a sample source and downstream threshold/statistics logic. It is the sequential successor to the team's combinational nbit comparator.

---
 rtl/nbit_comparator_stream_if.sv | 36 +++
 rtl/nbit_comparator_stream.sv | 118 +++++++++++
 tb/tb_nbit_comparator_stream.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nbit_comparator_stream_if.sv
// Stream bundle for nbit_comparator_stream: operand handshake, result handshake,
// clear strobe and the three outcome counters.
interface nbit_comparator_stream_if #(
  parameter int unsigned N     = 12,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             signed_mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic             smaller;
  logic             equal;
  logic             greater;
  logic             changed;
  logic [CNT_W-1:0] cnt_smaller;
  logic [CNT_W-1:0] cnt_equal;
  logic [CNT_W-1:0] cnt_greater;

  // Source/sink side (drives operands and out_ready, observes results).
  modport master (
    output in_valid, a, b, signed_mode, clear, out_ready,
    input  in_ready, out_valid, smaller, equal, greater, changed,
           cnt_smaller, cnt_equal, cnt_greater
  );

  // Comparator side.
  modport slave (
    input  in_valid, a, b, signed_mode, clear, out_ready,
    output in_ready, out_valid, smaller, equal, greater, changed,
           cnt_smaller, cnt_equal, cnt_greater
  );
endinterface

// File: rtl/nbit_comparator_stream.sv
// Registered, handshaked N-bit signed/unsigned magnitude comparator with a
// result-changed flag and saturating per-outcome counters.
module nbit_comparator_stream #(
  parameter int unsigned N     = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nbit_comparator_stream_if.slave      bus
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Result encoding is {smaller, equal, greater}.
  logic             out_valid_q, out_valid_d;
  logic [2:0]       res_q, res_d;
  logic             changed_q, changed_d;
  logic             prev_valid_q, prev_valid_d;
  logic [2:0]       prev_res_q, prev_res_d;
  logic [CNT_W-1:0] cnt_sm_q, cnt_sm_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;

  logic             in_ready;
  logic             accept;
  logic [N-1:0]     a_key, b_key;
  logic [2:0]       res_new;
  logic             hist_valid;
  logic [CNT_W-1:0] cnt_sm_base, cnt_eq_base, cnt_gt_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_key = bus.a ^ {bus.signed_mode, {(N-1){1'b0}}};
  assign b_key = bus.b ^ {bus.signed_mode, {(N-1){1'b0}}};

  always_comb begin
    res_new = 3'b000;
    if (a_key < b_key) begin
      res_new = 3'b100;
    end else if (a_key == b_key) begin
      res_new = 3'b010;
    end else begin
      res_new = 3'b001;
    end
  end

  // clear takes effect before an accept in the same cycle.
  assign hist_valid  = prev_valid_q && !bus.clear;
  assign cnt_sm_base = bus.clear ? '0 : cnt_sm_q;
  assign cnt_eq_base = bus.clear ? '0 : cnt_eq_q;
  assign cnt_gt_base = bus.clear ? '0 : cnt_gt_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    res_d        = res_q;
    changed_d    = changed_q;
    prev_valid_d = hist_valid;
    prev_res_d   = prev_res_q;
    cnt_sm_d     = cnt_sm_base;
    cnt_eq_d     = cnt_eq_base;
    cnt_gt_d     = cnt_gt_base;

    if (accept) begin
      out_valid_d  = 1'b1;
      res_d        = res_new;
      changed_d    = !hist_valid || (res_new != prev_res_q);
      prev_valid_d = 1'b1;
      prev_res_d   = res_new;
      unique case (res_new)
        3'b100:  cnt_sm_d = sat_inc(cnt_sm_base);
        3'b010:  cnt_eq_d = sat_inc(cnt_eq_base);
        3'b001:  cnt_gt_d = sat_inc(cnt_gt_base);
        default: ;
      endcase
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      res_q        <= 3'b000;
      changed_q    <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_res_q   <= 3'b000;
      cnt_sm_q     <= '0;
      cnt_eq_q     <= '0;
      cnt_gt_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      res_q        <= res_d;
      changed_q    <= changed_d;
      prev_valid_q <= prev_valid_d;
      prev_res_q   <= prev_res_d;
      cnt_sm_q     <= cnt_sm_d;
      cnt_eq_q     <= cnt_eq_d;
      cnt_gt_q     <= cnt_gt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.smaller     = res_q[2];
  assign bus.equal       = res_q[1];
  assign bus.greater     = res_q[0];
  assign bus.changed     = changed_q;
  assign bus.cnt_smaller = cnt_sm_q;
  assign bus.cnt_equal   = cnt_eq_q;
  assign bus.cnt_greater = cnt_gt_q;

endmodule

// File: tb/tb_nbit_comparator_stream.sv
// Directed self-checking bench for nbit_comparator_stream (N=12, CNT_W=2 so
// saturation is reachable quickly).
module tb_nbit_comparator_stream;

  localparam int unsigned N     = 12;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  nbit_comparator_stream_if #(.N(N), .CNT_W(CNT_W)) bus ();

  nbit_comparator_stream #(.N(N), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sm);
    bus.in_valid    = 1'b1;
    bus.a           = av;
    bus.b           = bv;
    bus.signed_mode = sm;
    step();
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.smaller, bus.equal, bus.greater};
  endfunction

  function automatic logic [31:0] cnts();
    return {26'd0, bus.cnt_smaller, bus.cnt_equal, bus.cnt_greater};
  endfunction

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.clear       = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_changed", {31'd0, bus.changed}, 32'd0);
    chk("rst_cnts", cnts(), 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    rst_n = 1'b1;

    // Unsigned basic, back-to-back
    send(12'd0, 12'd0, 1'b0);
    chk("b0_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b0_flags", flags(), 32'b010);
    chk("b0_changed", {31'd0, bus.changed}, 32'd1);
    send(12'd5, 12'd99, 1'b0);
    chk("b1_flags", flags(), 32'b100);
    chk("b1_changed", {31'd0, bus.changed}, 32'd1);
    send(12'd66, 12'd66, 1'b0);
    chk("b2_flags", flags(), 32'b010);
    chk("b2_changed", {31'd0, bus.changed}, 32'd1);
    send(12'd100, 12'd47, 1'b0);
    chk("b3_flags", flags(), 32'b001);
    chk("b3_changed", {31'd0, bus.changed}, 32'd1);
    chk("b3_cnts", cnts(), {26'd0, 2'd1, 2'd2, 2'd1});

    // Signed vs unsigned
    send(12'hFFF, 12'h001, 1'b1);
    chk("s0_flags", flags(), 32'b100);
    chk("s0_changed", {31'd0, bus.changed}, 32'd1);
    send(12'hFFF, 12'h001, 1'b0);
    chk("s1_flags", flags(), 32'b001);
    send(12'h800, 12'h7FF, 1'b1);
    chk("s2_flags", flags(), 32'b100);
    chk("s2_cnts", cnts(), {26'd0, 2'd3, 2'd2, 2'd2});

    // Clear alone while a result is held
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear     = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("clr_flags", flags(), 32'b100);
    chk("clr_cnts", cnts(), 32'd0);
    chk("clr_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    send(12'd10, 12'd3, 1'b0);
    chk("bp0_flags", flags(), 32'b001);
    chk("bp0_changed", {31'd0, bus.changed}, 32'd1);
    bus.a = 12'd2;
    bus.b = 12'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_flags", flags(), 32'b001);
      chk("bp_cnts", cnts(), {26'd0, 2'd0, 2'd0, 2'd1});
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("bp1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp1_flags", flags(), 32'b100);
    chk("bp1_cnts", cnts(), {26'd0, 2'd1, 2'd0, 2'd1});
    bus.in_valid = 1'b0;
    step();
    chk("bp_drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Change flag
    send(12'd7, 12'd7, 1'b0);
    chk("ch0", {31'd0, bus.changed}, 32'd1);
    send(12'd7, 12'd7, 1'b0);
    chk("ch1", {31'd0, bus.changed}, 32'd0);
    send(12'd7, 12'd7, 1'b0);
    chk("ch2", {31'd0, bus.changed}, 32'd0);
    send(12'd8, 12'd7, 1'b0);
    chk("ch3", {31'd0, bus.changed}, 32'd1);
    chk("ch3_cnts", cnts(), {26'd0, 2'd1, 2'd3, 2'd2});

    // Saturation
    bus.in_valid = 1'b0;
    bus.clear    = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("sat_clr_cnts", cnts(), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send(12'd3, 12'd3, 1'b0);
      chk("sat_eq", {30'd0, bus.cnt_equal}, (i >= 3) ? 32'd3 : i);
      chk("sat_changed", {31'd0, bus.changed}, (i == 1) ? 32'd1 : 32'd0);
    end
    bus.in_valid = 1'b0;
    step();
    chk("sat_hold", cnts(), {26'd0, 2'd0, 2'd3, 2'd0});
    chk("sat_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.clear = 1'b1;
    step();
    chk("clr2_cnts", cnts(), 32'd0);
    send(12'd1, 12'd2, 1'b0);
    bus.clear = 1'b0;
    chk("clracc_flags", flags(), 32'b100);
    chk("clracc_changed", {31'd0, bus.changed}, 32'd1);
    chk("clracc_cnts", cnts(), {26'd0, 2'd1, 2'd0, 2'd0});

    // Asynchronous reset between edges
    send(12'd5, 12'd1, 1'b0);
    chk("ar_pre_flags", flags(), 32'b001);
    #3;
    rst_n        = 1'b0;
    bus.a        = 12'd9;
    bus.b        = 12'd2;
    #1;
    chk("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_flags", flags(), 32'd0);
    chk("ar_changed", {31'd0, bus.changed}, 32'd0);
    chk("ar_cnts", cnts(), 32'd0);
    chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("ar_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    step();
    chk("ar_post_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_post_cnts", cnts(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
